// File: rtl/dcf77_signal_generator_if.sv
// Time/date inputs and modulated outputs of the DCF77 signal generator.
// The master drives time and control; the slave (generator) drives the signal.
interface dcf77_signal_generator_if;
    logic        enable;
    logic        dst;
    logic [6:0]  minute;
    logic [5:0]  hour;
    logic [5:0]  day;
    logic [2:0]  weekday;
    logic [4:0]  month;
    logic [7:0]  year;
    logic        dcf_out;
    logic        dcf_new_sec;
    logic [5:0]  sec_index;
    logic [58:0] dcf_bits;

    modport master (
        output enable, dst, minute, hour, day, weekday, month, year,
        input  dcf_out, dcf_new_sec, sec_index, dcf_bits
    );

    modport slave (
        input  enable, dst, minute, hour, day, weekday, month, year,
        output dcf_out, dcf_new_sec, sec_index, dcf_bits
    );
endinterface

// File: rtl/dcf77_signal_generator.sv
// DCF77 transmitter: encodes BCD time/date into a 59-bit minute frame and emits it
// as 100 ms / 200 ms carrier-reduction pulses, with no pulse in second 59.
module dcf77_signal_generator #(
    parameter int unsigned CLOCK_FREQUENCY = 16000000
) (
    input  logic                    clk,
    input  logic                    reset,
    dcf77_signal_generator_if.slave bus
);

    localparam int unsigned TickCycles = (CLOCK_FREQUENCY / 10 > 0) ? CLOCK_FREQUENCY / 10 : 1;
    localparam int unsigned PrescW     = (TickCycles > 1) ? $clog2(TickCycles) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TickCycles - 1);

    typedef enum logic [1:0] {StIdle, StGap, StPulse} state_e;

    state_e            state_q;
    logic [PrescW-1:0] presc_q;
    logic [3:0]        tick_q;
    logic [5:0]        sec_index_q;
    logic [58:0]       dcf_bits_q;
    logic              dcf_out_q;
    logic              new_sec_q;

    logic              tick_end;
    logic              sec_end;
    logic [58:0]       frame;

    assign tick_end = (presc_q == PrescMax);
    assign sec_end  = tick_end && (tick_q == 4'd9);

    always_comb begin
        frame        = '0;
        frame[17]    = bus.dst;
        frame[18]    = ~bus.dst;
        frame[20]    = 1'b1;
        frame[27:21] = bus.minute;
        frame[28]    = ^bus.minute;
        frame[34:29] = bus.hour;
        frame[35]    = ^bus.hour;
        frame[41:36] = bus.day;
        frame[44:42] = bus.weekday;
        frame[49:45] = bus.month;
        frame[57:50] = bus.year;
        frame[58]    = ^frame[57:36];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            tick_q      <= '0;
            sec_index_q <= 6'd59;
            dcf_bits_q  <= '0;
            dcf_out_q   <= 1'b0;
            new_sec_q   <= 1'b0;
        end else begin
            new_sec_q <= 1'b0;
            if (!bus.enable) begin
                state_q     <= StIdle;
                presc_q     <= '0;
                tick_q      <= '0;
                sec_index_q <= 6'd59;
                dcf_out_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Start with the gap second so receivers can find minute sync
                        state_q     <= StGap;
                        new_sec_q   <= 1'b1;
                        presc_q     <= '0;
                        tick_q      <= '0;
                        sec_index_q <= 6'd59;
                        dcf_out_q   <= 1'b0;
                    end
                    StGap, StPulse: begin
                        presc_q <= tick_end ? '0 : presc_q + PrescW'(1);
                        if (tick_end) begin
                            tick_q <= (tick_q == 4'd9) ? 4'd0 : tick_q + 4'd1;
                        end
                        if (sec_end) begin
                            new_sec_q <= 1'b1;
                            dcf_out_q <= 1'b1;
                            if (state_q == StGap) begin
                                dcf_bits_q  <= frame;
                                sec_index_q <= 6'd0;
                                state_q     <= StPulse;
                            end else if (sec_index_q == 6'd58) begin
                                sec_index_q <= 6'd59;
                                dcf_out_q   <= 1'b0;
                                state_q     <= StGap;
                            end else begin
                                sec_index_q <= sec_index_q + 6'd1;
                            end
                        end else if (tick_end) begin
                            // A '1' bit keeps the pulse high through tick 1
                            dcf_out_q <= (state_q == StPulse) && (tick_q == 4'd0) &&
                                         dcf_bits_q[sec_index_q];
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.dcf_out     = dcf_out_q;
    assign bus.dcf_new_sec = new_sec_q;
    assign bus.sec_index   = sec_index_q;
    assign bus.dcf_bits    = dcf_bits_q;

endmodule

// File: tb/tb_dcf77_signal_generator.sv
// Directed bench for the DCF77 generator: expected frames are queued when inputs change
// and compared when the generator latches a new frame at second 0.
module tb_dcf77_signal_generator;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [58:0] exp_q[$];
    logic [58:0] cur;
    logic [58:0] popped;
    int   high;
    int   len;

    dcf77_signal_generator_if bus ();

    dcf77_signal_generator #(
        .CLOCK_FREQUENCY(100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [58:0] model_frame(input logic d, input logic [6:0] mi,
                                                input logic [5:0] hr, input logic [5:0] dy,
                                                input logic [2:0] wd, input logic [4:0] mo,
                                                input logic [7:0] yr);
        logic [21:0] date;
        date = {yr, mo, wd, dy};
        return {^date, date, ^hr, hr, ^mi, mi, 1'b1, 1'b0, ~d, d, 17'b0};
    endfunction

    function automatic logic [58:0] cur_model();
        return model_frame(bus.dst, bus.minute, bus.hour, bus.day, bus.weekday, bus.month,
                           bus.year);
    endfunction

    task automatic pop_frame(input string tag, output logic [58:0] f);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(0), 64'(1));
            f = '0;
        end else begin
            f = exp_q.pop_front();
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        while (!bus.dcf_new_sec && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.dcf_new_sec) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    // Entered on the strobe cycle of a second; returns at the strobe of the next one.
    task automatic run_second(output int h, output int l);
        h = 0;
        l = 0;
        do begin
            if (bus.dcf_out) h++;
            l++;
            @(negedge clk);
        end while (!bus.dcf_new_sec && l < 300);
    endtask

    task automatic run_pulses(input int first, input int last, input logic [58:0] f);
        for (int s = first; s <= last; s++) begin
            check($sformatf("sec_index_%0d", s), 64'(bus.sec_index), 64'(s));
            check($sformatf("rise_%0d", s), 64'(bus.dcf_out), 64'(1));
            if (s == 30) begin
                bus.minute = 7'h35;
                exp_q.push_back(cur_model());
            end
            run_second(high, len);
            check($sformatf("pulse_%0d", s), 64'(high), 64'(f[s] ? 20 : 10));
            check($sformatf("len_%0d", s), 64'(len), 64'(100));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.enable  = 1'b1;
        bus.dst     = 1'b0;
        bus.minute  = 7'h34;
        bus.hour    = 6'h12;
        bus.day     = 6'h17;
        bus.weekday = 3'd5;
        bus.month   = 5'h05;
        bus.year    = 8'h24;
        repeat (3) @(negedge clk);
        check("rst_dcf_out", 64'(bus.dcf_out), 64'(0));
        check("rst_new_sec", 64'(bus.dcf_new_sec), 64'(0));
        check("rst_sec_index", 64'(bus.sec_index), 64'(59));
        check("rst_dcf_bits", 64'(bus.dcf_bits), 64'(0));
        reset = 1'b1;
        exp_q.push_back(cur_model());

        // Initial gap second
        wait_strobe("start");
        check("gap0_sec_index", 64'(bus.sec_index), 64'(59));
        run_second(high, len);
        check("gap0_high", 64'(high), 64'(0));
        check("gap0_len", 64'(len), 64'(100));

        // First frame
        pop_frame("frame1", cur);
        check("frame1_bits", 64'(bus.dcf_bits), 64'(cur));
        check("frame1_minute", 64'(bus.dcf_bits[27:21]), 64'(7'h34));
        check("frame1_min_par", 64'(bus.dcf_bits[28]), 64'(1));
        check("frame1_hour", 64'(bus.dcf_bits[34:29]), 64'(6'h12));
        check("frame1_hour_par", 64'(bus.dcf_bits[35]), 64'(0));
        check("frame1_bit18", 64'(bus.dcf_bits[18]), 64'(1));
        check("frame1_bit20", 64'(bus.dcf_bits[20]), 64'(1));
        check("frame1_bit0", 64'(bus.dcf_bits[0]), 64'(0));
        run_pulses(0, 58, cur);

        check("gap1_sec_index", 64'(bus.sec_index), 64'(59));
        check("gap1_frame_held", 64'(bus.dcf_bits), 64'(cur));
        run_second(high, len);
        check("gap1_high", 64'(high), 64'(0));
        check("gap1_len", 64'(len), 64'(100));

        // Second frame carries the minute changed mid-frame
        pop_frame("frame2", cur);
        check("frame2_bits", 64'(bus.dcf_bits), 64'(cur));
        check("frame2_minute", 64'(bus.dcf_bits[27:21]), 64'(7'h35));
        check("frame2_min_par", 64'(bus.dcf_bits[28]), 64'(0));
        bus.dst = 1'b1;
        exp_q.push_back(cur_model());
        run_pulses(0, 19, cur);

        // Abort during the second tick of the '1' pulse in second 20
        check("abort_sec_index", 64'(bus.sec_index), 64'(20));
        repeat (15) @(negedge clk);
        check("abort_pre_high", 64'(bus.dcf_out), 64'(1));
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_dcf_out", 64'(bus.dcf_out), 64'(0));
        check("abort_sec_index59", 64'(bus.sec_index), 64'(59));
        repeat (5) @(negedge clk);
        check("idle_dcf_out", 64'(bus.dcf_out), 64'(0));
        check("idle_new_sec", 64'(bus.dcf_new_sec), 64'(0));
        check("idle_frame_held", 64'(bus.dcf_bits), 64'(cur));
        bus.enable = 1'b1;

        wait_strobe("restart");
        check("gap2_sec_index", 64'(bus.sec_index), 64'(59));
        run_second(high, len);
        check("gap2_high", 64'(high), 64'(0));
        check("gap2_len", 64'(len), 64'(100));
        pop_frame("frame3", cur);
        check("frame3_bits", 64'(bus.dcf_bits), 64'(cur));
        check("frame3_bit17", 64'(bus.dcf_bits[17]), 64'(1));
        check("frame3_bit18", 64'(bus.dcf_bits[18]), 64'(0));
        check("frame3_sec_index", 64'(bus.sec_index), 64'(0));
        check("frame3_rise", 64'(bus.dcf_out), 64'(1));

        // Asynchronous reset in the middle of a pulse
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_dcf_out", 64'(bus.dcf_out), 64'(0));
        check("areset_new_sec", 64'(bus.dcf_new_sec), 64'(0));
        check("areset_dcf_bits", 64'(bus.dcf_bits), 64'(0));
        check("areset_sec_index", 64'(bus.sec_index), 64'(59));
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcf77_signal_generator.md
Name: dcf77_signal_generator

Overview:
- Transmit-side counterpart of the DCF77 receive path: encodes a BCD time/date into a 59-bit DCF77 minute frame with even parity bits.
- Emits the frame as the standard pulse-width-modulated seconds signal: 100 ms pulse = 0, 200 ms pulse = 1, no pulse in second 59.
- Used as an on-chip DCF77 source for loopback testing of the receiver/validity logic and as a time-signal output pin driven by software-set time.

Parameters:
- CLOCK_FREQUENCY, 16000000, clk frequency in Hz; tick period = CLOCK_FREQUENCY/10 cycles (100 ms), integer division.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = generate signal; 0 = idle, output low
- dst  in  1  1 = CEST (bit17=1, bit18=0); 0 = CET (bit17=0, bit18=1)
- minute  in  7  BCD minute 00-59
- hour  in  6  BCD hour 00-23
- day  in  6  BCD day of month 01-31
- weekday  in  3  1=Mon .. 7=Sun
- month  in  5  BCD month 01-12
- year  in  8  BCD year 00-99
- dcf_out  out  1  modulated signal, 1 = carrier reduction (pulse)
- dcf_new_sec  out  1  one-cycle strobe at the start of every transmitted second, including 59
- sec_index  out  6  current second 0-59
- dcf_bits  out  59  frame currently being transmitted (bit n = second n)

Behaviour:
- Reset (reset=0): dcf_out=0, dcf_new_sec=0, sec_index=59, dcf_bits=0, prescaler=0, tick count=0, state IDLE.
- Prescaler: counts 0..CLOCK_FREQUENCY/10-1; wrap produces tick. Tick counter 0..9 within a second; wrap after 9 advances the second.
- States:
  - IDLE: dcf_out=0, counters held at 0, sec_index=59. Enable rising → GAP at second 59, with dcf_new_sec pulsed that cycle. Starting with the gap lets receivers find minute sync.
  - GAP (second 59): dcf_out=0 for all 10 ticks. At the end of the second:
    - build the frame from the inputs sampled in that cycle; write it to dcf_bits;
    - sec_index=0, dcf_new_sec=1 → PULSE.
  - PULSE (seconds 0-58): dcf_out=1 for 1 tick if dcf_bits[sec_index]=0, for 2 ticks if 1; then 0 for the rest of the second.
    - At each second end, sec_index+1 and dcf_new_sec=1.
    - After second 58, go to GAP with sec_index=59.
- Timing: dcf_out rises in the same cycle as dcf_new_sec (registered, both asserted together); second length is exactly 10*(CLOCK_FREQUENCY/10) cycles.
- Frame layout (even parity, XOR of data bits = parity bit):
  - bit0=0; bits1-16=0; bit17=dst; bit18=~dst; bit19=0; bit20=1
  - bits21-27=minute, bit28=^bits[27:21]
  - bits29-34=hour, bit35=^bits[34:29]
  - bits36-41=day, bits42-44=weekday, bits45-49=month, bits50-57=year
  - bit58=^bits[57:36]
  - BCD fields are LSB first (lower index = lower bit).
- Input handling: inputs are sampled only at the 59→0 boundary; changes mid-frame have no effect until the next frame. No range checking: out-of-range BCD is transmitted as given, with correct parity.
- enable deasserted in any state: next cycle dcf_out=0 and the block enters IDLE with counters cleared, aborting any pulse. dcf_bits keeps its last frame.
- Enable re-asserted: restarts at second 59 (full 1 s gap before second 0).
- Asynchronous reset mid-pulse forces dcf_out=0 immediately.

Test Plan:
- CLOCK_FREQUENCY=100 (10 cycles/tick), enable=1 from reset, time 12:34 CET, 2024-05-17 Fri -> first 100 cycles dcf_out=0; then dcf_bits[27:21]=7'h34, bit28=1, bits[34:29]=6'h12, bit35=0, bit18=1, bit20=1, bit0=0; parity bits match XOR.
- Same run -> second 0 pulse 10 cycles high; second 20 pulse 20 cycles high; second 59 no pulse; dcf_new_sec every 100 cycles; sec_index sequence 59,0..59,0.
- Change minute to 8'h35 at second 30 -> current frame unchanged; next frame bits[27:21]=7'h35 with parity bit28=0.
- Deassert enable during the second tick of a '1' pulse -> dcf_out=0 next cycle, sec_index=59. Re-enable -> 100 cycles low, then second 0.
- Loopback: connect dcf_bits and dcf_new_sec to the validity checker -> signal_valid=1 at each strobe after the first frame. Force dst=1 -> bits 17/18 = 1/0, still valid.
- Assert reset low during a pulse -> dcf_out, dcf_new_sec and dcf_bits are 0 asynchronously; sec_index=59.
